bcd_counter_chain: RTL

- Parametrised, fully synchronous successor to the team's ripple decade counter.
- A chain of DIGITS radix-MODULUS digit counters.
- Supports:
  - up/down counting with count enable
  - decade-style clear-to-zero (r0) and preset-to-nine (r9) controls
  - parallel load
  - chained terminal-count/carry output for cascading blocks
- Used as the event/time-base counter in display and frequency-measurement paths; replaces asynchronous JK ripple chains.

---
 rtl/bcd_chain_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 54 +++++
 rtl/bcd_counter_chain.sv | 83 ++++++++
 3 files changed

// File: rtl/bcd_chain_pkg.sv
// Shared constants and digit helpers for the synchronous BCD/radix counter chain.
package bcd_chain_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // Limits a raw nibble to the largest legal digit for the given radix.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                       input int modulus);
        if (int'(value) >= modulus) begin
            return DIGIT_W'(modulus - 1);
        end
        return value;
    endfunction

    // A digit is terminal when the next step in the current direction wraps it.
    function automatic logic is_term(input logic [DIGIT_W-1:0] digit,
                                     input int modulus,
                                     input logic up);
        if (up) begin
            return (int'(digit) == (modulus - 1));
        end
        return (digit == '0);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One radix-MODULUS digit of the counter chain with clear, preset, load and step.
module bcd_digit
    import bcd_chain_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               r0_i,
    input  logic               r9_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] loadNibble_i,
    input  logic               stepEn_i,
    input  logic               up_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               term_o
);

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit value: preset beats clear beats load beats a count step.
    always_comb begin
        digit_d = digit_q;
        if (r9_i) begin
            digit_d = DIGIT_MAX;
        end else if (r0_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = clamp_digit(loadNibble_i, MODULUS);
        end else if (stepEn_i) begin
            if (up_i) begin
                digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 1'b1;
            end else begin
                digit_d = (digit_q == '0) ? DIGIT_MAX : digit_q - 1'b1;
            end
        end
    end

    // Digit register with synchronous reset to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign term_o  = is_term(digit_q, MODULUS, up_i);

endmodule

// File: rtl/bcd_counter_chain.sv
// Fully synchronous chain of DIGITS radix-MODULUS counters with terminal count/carry.
// Optional sticky wrap flag on ovf_o is enabled by defining BCD_CHAIN_OVF_STICKY_EN.
module bcd_counter_chain
    import bcd_chain_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      up_i,
    input  logic                      r0_i,
    input  logic                      r9_i,
    input  logic                      load_i,
    input  logic [DIGIT_W*DIGITS-1:0] load_val_i,
    output logic [DIGIT_W*DIGITS-1:0] count_o,
    output logic                      tc_o,
    output logic                      carry_o,
    output logic                      ovf_o
);

    logic [DIGITS-1:0] termFlags;
    logic [DIGITS:0]   stepChain;

    // Digit k steps only when enabled and every lower digit is about to wrap,
    // so the whole carry resolves within one cycle.
    assign stepChain[0] = en_i;

    for (genvar k = 0; k < DIGITS; k++) begin : gDigit
        bcd_digit #(
            .MODULUS(MODULUS)
        ) uDigit (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .r0_i        (r0_i),
            .r9_i        (r9_i),
            .load_i      (load_i),
            .loadNibble_i(load_val_i[k*DIGIT_W +: DIGIT_W]),
            .stepEn_i    (stepChain[k]),
            .up_i        (up_i),
            .digit_o     (count_o[k*DIGIT_W +: DIGIT_W]),
            .term_o      (termFlags[k])
        );
        assign stepChain[k+1] = stepChain[k] & termFlags[k];
    end

    assign tc_o    = &termFlags;
    assign carry_o = stepChain[DIGITS];

`ifdef BCD_CHAIN_OVF_STICKY_EN
    logic ovf_q;
    logic ovf_d;
    logic stepTaken;

    // A step only happens when no clear, preset or load claims the cycle.
    assign stepTaken = carry_o & ~r9_i & ~r0_i & ~load_i;

    // Sticky flag: cleared by an effective clear, set by any full wrap.
    always_comb begin
        ovf_d = ovf_q;
        if (r0_i && !r9_i) begin
            ovf_d = 1'b0;
        end else if (stepTaken) begin
            ovf_d = 1'b1;
        end
    end

    // Wrap flag register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule
